// File: rtl/tp_mem_stream_reader.sv
// tp_mem_stream_reader
// Read-side initiator for the two-port activation/weight memories. A strided
// burst command is turned into a sequence of memory reads; returned words are
// buffered in a small credit-protected FIFO and streamed out over valid/ready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (accepted only in IDLE)
//   cmd_addr, cmd_len, cmd_stride start address, word count (0..2^ADDR_W), stride
//   mem_rd_en, mem_rd_addr        registered read strobe/address to the memory
//   mem_rd_word                   read data, valid RD_LAT cycles after the strobe
//   out_valid/out_ready           output stream handshake
//   out_data, out_last            FIFO head word and final-word flag
//   busy                          low only when idle, FIFO empty, nothing in flight
//
// state | meaning
// IDLE  | waiting for a command; FIFO empty and no reads in flight
// ISSUE | issuing reads whenever a FIFO credit is free
// DRAIN | all reads issued; waiting for the last word to be handshaken
module tp_mem_stream_reader #(
   parameter int DATA_W     = 4096,
   parameter int ADDR_W     = 9,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic [ADDR_W-1:0] cmd_stride,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] cur_addr, stride;
   logic [ADDR_W:0]   remaining;
   logic              rd_last_q;
   logic [RD_LAT-1:0] dl_v, dl_l;
   logic [CW-1:0]     inflight, count;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic              fifo_last [FIFO_DEPTH];

   logic              issue, issue_last, push, pop, can_issue, cmd_fire;
   logic [ADDR_W-1:0] issue_addr;

   assign push      = dl_v[RD_LAT-1];
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign out_data  = fifo_data[rd_ptr];
   assign out_last  = out_valid & fifo_last[rd_ptr];
   assign cmd_ready = (state == IDLE);
   assign cmd_fire  = cmd_ready & cmd_valid;
   assign busy      = (state != IDLE) || (count != '0) || (inflight != '0);
   // Credits cover both words still in the memory pipeline and words buffered.
   assign can_issue = ({1'b0, inflight} + {1'b0, count}) < {1'b0, FULL_C};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      issue      = 1'b0;
      issue_addr = cur_addr;
      issue_last = 1'b0;
      unique case (state)
         IDLE: begin
            // The first read is issued on the handshake edge itself.
            if (cmd_valid && cmd_len != '0) begin
               issue      = 1'b1;
               issue_addr = cmd_addr;
               issue_last = (cmd_len == ONE_LEN);
               state_n    = (cmd_len == ONE_LEN) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (can_issue) begin
               issue      = 1'b1;
               issue_last = (remaining == ONE_LEN);
               if (remaining == ONE_LEN) state_n = DRAIN;
            end
         end
         DRAIN: begin
            // Leave on the edge that pops the final word.
            if (inflight == '0 && (count == '0 || (count == CW'(1) && pop)))
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         rd_last_q   <= 1'b0;
         cur_addr    <= '0;
         stride      <= '0;
         remaining   <= '0;
         dl_v        <= '0;
         dl_l        <= '0;
         inflight    <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         mem_rd_en <= issue;
         rd_last_q <= issue & issue_last;
         if (issue) mem_rd_addr <= issue_addr;

         if (cmd_fire) begin
            stride    <= cmd_stride;
            cur_addr  <= cmd_addr + cmd_stride;
            remaining <= cmd_len - ONE_LEN;
         end else if (state == ISSUE && issue) begin
            cur_addr  <= cur_addr + stride;
            remaining <= remaining - ONE_LEN;
         end

         dl_v[0] <= mem_rd_en;
         dl_l[0] <= rd_last_q;
         for (int i = 1; i < RD_LAT; i++) begin
            dl_v[i] <= dl_v[i-1];
            dl_l[i] <= dl_l[i-1];
         end

         if (issue && !push)      inflight <= inflight + CW'(1);
         else if (!issue && push) inflight <= inflight - CW'(1);

         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);

         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset: contents are only observed while count != 0.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= mem_rd_word;
         fifo_last[wr_ptr] <= dl_l[RD_LAT-1];
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && count == FULL_C));

endmodule

// File: tb/tb_tp_mem_stream_reader.sv
module tb_tp_mem_stream_reader;
   localparam int DATA_W = 4096;
   localparam int ADDR_W = 9;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [ADDR_W:0]   cmd_len = '0;
   logic [ADDR_W-1:0] cmd_stride = '0;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_word = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int hs_cyc   = 0;
   int rdy_mode = 1;
   int rd_pulses = 0;
   int valid_cnt = 0;
   int last_cnt  = 0;

   exp_t              exp_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];

   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic              prev_last = 1'b0;

   tp_mem_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_word(mem_rd_word),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      w = '0;
      w[ADDR_W-1:0] = a;
      w[2048 +: 16] = {7'd0, a} ^ 16'h5a5a;
      w[DATA_W-1 -: ADDR_W] = ~a;
      return w;
   endfunction

   function automatic logic [63:0] show(input logic [DATA_W-1:0] w);
      return {w[DATA_W-1 -: 32], w[31:0]};
   endfunction

   // Memory model, one cycle read latency.
   always @(posedge clk) if (mem_rd_en) mem_rd_word <= mem_fn(mem_rd_addr);

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: read-address and output-word scoreboards plus stall stability.
   always @(negedge clk) begin
      exp_t e;
      logic [ADDR_W-1:0] ea;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (mem_rd_en) begin
            rd_pulses++;
            if (exp_addr_q.size() == 0) check("rd_unexpected", 1'b0, 64'(mem_rd_addr), 64'hffff);
            else begin
               ea = exp_addr_q.pop_front();
               check("rd_addr", mem_rd_addr == ea, 64'(mem_rd_addr), 64'(ea));
            end
         end
         if (out_valid) valid_cnt++;
         if (prev_stall)
            check("stall_stable", out_valid && out_data == prev_data && out_last == prev_last,
                  show(out_data) ^ 64'(out_last), show(prev_data) ^ 64'(prev_last));
         if (out_valid && out_ready) begin
            if (out_last) last_cnt++;
            if (exp_q.size() == 0) check("out_unexpected", 1'b0, show(out_data), 64'h0);
            else begin
               e = exp_q.pop_front();
               check("out_data", out_data == e.data, show(out_data), show(e.data));
               check("out_last", out_last == e.last, 64'(out_last), 64'(e.last));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready == 1'b1, 64'(cmd_ready), 64'd1);
      check({tag, "_rd_en"}, mem_rd_en == 1'b0, 64'(mem_rd_en), 64'd0);
      check({tag, "_rd_addr"}, mem_rd_addr == '0, 64'(mem_rd_addr), 64'd0);
      check({tag, "_out_valid"}, out_valid == 1'b0, 64'(out_valid), 64'd0);
      check({tag, "_out_last"}, out_last == 1'b0, 64'(out_last), 64'd0);
      check({tag, "_busy"}, busy == 1'b0, 64'(busy), 64'd0);
   endtask

   // Queues the expected reads/words, then performs one command handshake.
   task automatic send_cmd(input int a, input int l, input int s);
      int t;
      for (int k = 0; k < l; k++) begin
         logic [ADDR_W-1:0] ad;
         exp_t e;
         ad = ADDR_W'((a + k * s) % 512);
         exp_addr_q.push_back(ad);
         e.data = mem_fn(ad);
         e.last = (k == l - 1);
         exp_q.push_back(e);
      end
      t = 0;
      while (!cmd_ready && t < 300) begin
         @(posedge clk); #1; t++;
      end
      check("cmd_ready_wait", cmd_ready == 1'b1, 64'(t), 64'd300);
      cmd_valid  = 1'b1;
      cmd_addr   = ADDR_W'(a);
      cmd_len    = (ADDR_W + 1)'(l);
      cmd_stride = ADDR_W'(s);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      hs_cyc = cyc;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < budget) begin
         @(negedge clk); t++;
      end
      check({tag, "_done"}, t < budget, 64'(t), 64'(budget));
      check({tag, "_words_left"}, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
      check({tag, "_reads_left"}, exp_addr_q.size() == 0, 64'(exp_addr_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, lbase;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset("reset");

      // Directed burst: cycle-exact issue/output/busy timeline.
      @(posedge clk); #1;
      rdy_mode = 1;
      send_cmd(0, 4, 1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("t1_rd_en_c%0d", k), mem_rd_en == (k >= 1 && k <= 4), 64'(mem_rd_en), 64'(k <= 4));
         if (k <= 4) check($sformatf("t1_rd_addr_c%0d", k), mem_rd_addr == ADDR_W'(k - 1), 64'(mem_rd_addr), 64'(k - 1));
         check($sformatf("t1_valid_c%0d", k), out_valid == (k >= 3 && k <= 6), 64'(out_valid), 64'(k >= 3 && k <= 6));
         check($sformatf("t1_last_c%0d", k), out_last == (k == 6), 64'(out_last), 64'(k == 6));
         check($sformatf("t1_busy_c%0d", k), busy == (k < 7), 64'(busy), 64'(k < 7));
         check($sformatf("t1_cmd_ready_c%0d", k), cmd_ready == (k >= 7), 64'(cmd_ready), 64'(k >= 7));
      end
      wait_idle("t1", 50);

      // Address wrap.
      send_cmd(510, 4, 1);
      wait_idle("t2", 50);

      // Backpressure: credits limit outstanding reads to FIFO depth.
      rdy_mode = 0;
      @(posedge clk); #1;
      base = rd_pulses;
      send_cmd(0, 8, 1);
      repeat (20) @(posedge clk);
      #1;
      check("t3_pulses_stalled", rd_pulses - base == 4, 64'(rd_pulses - base), 64'd4);
      rdy_mode = 1;
      wait_idle("t3", 100);
      check("t3_pulses_total", rd_pulses - base == 8, 64'(rd_pulses - base), 64'd8);

      // Random backpressure, stride 3.
      @(posedge clk); #1;
      rdy_mode = 2;
      lbase = last_cnt;
      send_cmd(0, 100, 3);
      wait_idle("t4", 2000);
      check("t4_one_last", last_cnt - lbase == 1, 64'(last_cnt - lbase), 64'd1);
      rdy_mode = 1;

      // Zero-length command.
      @(posedge clk); #1;
      base  = rd_pulses;
      lbase = valid_cnt;
      send_cmd(7, 0, 1);
      @(negedge clk);
      check("t5_cmd_ready_next", cmd_ready == 1'b1, 64'(cmd_ready), 64'd1);
      check("t5_busy", busy == 1'b0, 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      check("t5_no_reads", rd_pulses == base, 64'(rd_pulses - base), 64'd0);
      check("t5_no_valid", valid_cnt == lbase, 64'(valid_cnt - lbase), 64'd0);

      // Reset in the middle of a burst.
      @(posedge clk); #1;
      send_cmd(32, 16, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      @(negedge clk);
      check_reset("t6_reset");
      base  = rd_pulses;
      lbase = valid_cnt;
      repeat (10) @(negedge clk);
      check("t6_no_stray_valid", valid_cnt == lbase, 64'(valid_cnt - lbase), 64'd0);
      check("t6_no_stray_reads", rd_pulses == base, 64'(rd_pulses - base), 64'd0);
      @(posedge clk); #1;
      send_cmd(100, 2, 7);
      wait_idle("t6_after", 50);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
